// File: rtl/opsum_fifo_ctrl.sv
// opsum_fifo_ctrl: moves PE output partial sums into the opsum FIFO and
// drains that FIFO to the GLB as halfword writes, one task of N results.
//
// Ports (parameters DATA_W=16, ADDR_W=32, CNT_W=32):
//   clk, rst_n                   clock, async active-low reset
//   opsum_fifo_reset_i           sync clear of state, counters, write pointer
//   opsum_need_push_i            task trigger (IDLE only)
//   opsum_push_num_i             results expected this task
//   opsum_fifo_base_addr_i       GLB byte base of the opsum region
//   pe_opsum_valid_i/data_i      PE result stream
//   pe_opsum_ready_o             controller accepts a PE result
//   opsum_fifo_full_i/empty_i    FIFO status (registered, one cycle stale)
//   opsum_fifo_push_o/data_o     FIFO push side
//   opsum_fifo_pop_o/pop_data_i  FIFO pop side (show-ahead head)
//   opsum_write_req_o            GLB write request to arbiter
//   opsum_permit_write_i         same-cycle arbiter grant
//   opsum_glb_write_addr_o/data_o/wstrb_o  GLB write bus
//   opsum_fifo_done_o            one-cycle task-complete pulse
//
// Build option: define OPSUM_RELU_EN to clamp negative heads to 0 on the
// GLB write path (FIFO contents are not modified).

module opsum_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              opsum_fifo_reset_i,
    input  logic              opsum_need_push_i,
    input  logic [CNT_W-1:0]  opsum_push_num_i,
    input  logic [ADDR_W-1:0] opsum_fifo_base_addr_i,
    input  logic              pe_opsum_valid_i,
    input  logic [DATA_W-1:0] pe_opsum_data_i,
    output logic              pe_opsum_ready_o,
    input  logic              opsum_fifo_full_i,
    input  logic              opsum_fifo_empty_i,
    output logic              opsum_fifo_push_o,
    output logic [DATA_W-1:0] opsum_fifo_push_data_o,
    output logic              opsum_fifo_pop_o,
    input  logic [DATA_W-1:0] opsum_fifo_pop_data_i,
    output logic              opsum_write_req_o,
    input  logic              opsum_permit_write_i,
    output logic [ADDR_W-1:0] opsum_glb_write_addr_o,
    output logic [31:0]       opsum_glb_write_data_o,
    output logic [3:0]        opsum_glb_wstrb_o,
    output logic              opsum_fifo_done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_push_cnt;
    logic [CNT_W-1:0]    r_pop_cnt;
    logic [ADDR_W-1:0]   r_write_ptr;

    logic                w_in_idle;
    logic                w_in_push;
    logic                w_in_drain;
    logic                w_in_done;
    logic                w_trigger;
    logic                w_ready;
    logic                w_push;
    logic                w_last_push;
    logic                w_req;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_head;

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_in_push  = (r_state == S_PUSH);
    assign w_in_drain = (r_state == S_DRAIN);
    assign w_in_done  = (r_state == S_DONE);

    assign w_trigger  = w_in_idle && opsum_need_push_i;

    assign w_ready    = w_in_push && !opsum_fifo_full_i
                        && (r_push_cnt < r_num);
    assign w_push     = w_ready && pe_opsum_valid_i;
    // push_cnt+1 avoids the num-1 underflow when num is 0
    assign w_last_push = w_push
                         && ((r_push_cnt + CNT_W'(1)) == r_num);

    assign w_req      = w_in_drain && !opsum_fifo_empty_i;
    assign w_pop      = w_req && opsum_permit_write_i;

    assign w_addr     = opsum_fifo_base_addr_i + r_write_ptr;

`ifdef OPSUM_RELU_EN
    assign w_head = opsum_fifo_pop_data_i[DATA_W-1]
                    ? '0 : opsum_fifo_pop_data_i;
`else
    assign w_head = opsum_fifo_pop_data_i;
`endif

    // Outputs
    assign pe_opsum_ready_o       = w_ready;
    assign opsum_fifo_push_o      = w_push;
    assign opsum_fifo_push_data_o = w_push ? pe_opsum_data_i : '0;
    assign opsum_fifo_pop_o       = w_pop;
    assign opsum_write_req_o      = w_req;
    assign opsum_fifo_done_o      = w_in_done;

    // Write bus is quiet unless a request is up
    always_comb begin
        opsum_glb_write_addr_o = '0;
        opsum_glb_write_data_o = '0;
        opsum_glb_wstrb_o      = '0;
        if (w_req) begin
            opsum_glb_write_addr_o = w_addr;
            opsum_glb_write_data_o = {w_head, w_head};
            opsum_glb_wstrb_o      = w_addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Next-state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (opsum_need_push_i) begin
                    w_state_nxt = (opsum_push_num_i != '0)
                                  ? S_PUSH : S_DONE;
                end
            end
            S_PUSH: begin
                // full and last push together both lead to DRAIN
                if (opsum_fifo_full_i || w_last_push) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // empty is one cycle stale, so the cycle after the
                // final pop shows empty with req low
                if (opsum_fifo_empty_i) begin
                    w_state_nxt = (r_pop_cnt == r_num)
                                  ? S_DONE : S_PUSH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (opsum_fifo_reset_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Task bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= '0;
            r_push_cnt <= '0;
            r_pop_cnt  <= '0;
        end else if (opsum_fifo_reset_i) begin
            r_num      <= '0;
            r_push_cnt <= '0;
            r_pop_cnt  <= '0;
        end else if (w_trigger) begin
            r_num      <= opsum_push_num_i;
            r_push_cnt <= '0;
            r_pop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_push_cnt <= r_push_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + CNT_W'(1);
            end
        end
    end

    // Write pointer persists across tasks so results append
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_ptr <= '0;
        end else if (opsum_fifo_reset_i) begin
            r_write_ptr <= '0;
        end else if (w_pop) begin
            r_write_ptr <= r_write_ptr + ADDR_W'(2);
        end
    end

endmodule

// File: doc/opsum_fifo_ctrl.md
Name: opsum_fifo_ctrl

Overview:
Token-engine controller for the output-partial-sum path, directly downstream of the PE array.
- Accepts opsum results from the PE array and pushes them into the opsum FIFO.
- Drains the FIFO to the GLB as halfword writes, arbitrated against the ipsum/weight/ifmap readers.
- Counts a task of N results and signals completion to the L2 controller.

Parameters:
DATA_W, 16, width of one psum entry (FIFO and PE side)
ADDR_W, 32, GLB byte-address width
CNT_W, 32, width of the task result counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opsum_fifo_reset_i  in  1  sync clear: state, counters, write pointer
opsum_need_push_i  in  1  new-task trigger, sampled only in IDLE
opsum_push_num_i  in  CNT_W  results expected this task, latched at trigger
opsum_fifo_base_addr_i  in  ADDR_W  GLB base byte address of opsum region
pe_opsum_valid_i  in  1  PE result valid
pe_opsum_data_i  in  DATA_W  PE result
pe_opsum_ready_o  out  1  controller accepts PE result
opsum_fifo_full_i  in  1  FIFO full
opsum_fifo_empty_i  in  1  FIFO empty
opsum_fifo_push_o  out  1  FIFO push strobe
opsum_fifo_push_data_o  out  DATA_W  FIFO push data
opsum_fifo_pop_o  out  1  FIFO pop strobe
opsum_fifo_pop_data_i  in  DATA_W  FIFO head (show-ahead, valid when !empty)
opsum_write_req_o  out  1  GLB write request to arbiter
opsum_permit_write_i  in  1  arbiter grant, same cycle
opsum_glb_write_addr_o  out  ADDR_W  GLB byte address
opsum_glb_write_data_o  out  32  GLB write data
opsum_glb_wstrb_o  out  4  active-high byte enables
opsum_fifo_done_o  out  1  one-cycle task-complete pulse

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low. On reset: state IDLE, all counters and write_ptr 0, all outputs 0.
- States: IDLE, PUSH, DRAIN, DONE.
- IDLE:
  - On need_push_i, latch num ← push_num_i and clear push_cnt/pop_cnt.
  - Go to PUSH if num≠0, else DONE.
- PUSH:
  - pe_ready_o = !full_i && push_cnt<num.
  - push_o = pe_ready_o && pe_valid_i; push_data_o = pe_opsum_data_i; push_cnt++ on push.
  - Go to DRAIN when full_i, or when push_o && push_cnt==num-1.
- DRAIN:
  - write_req_o = !empty_i; pop_o = write_req_o && permit_write_i; pop_cnt++ on pop.
  - Address = base + write_ptr. Data = {head,head}. wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - write_ptr += 2 per pop, wrapping modulo 2^ADDR_W.
  - When empty_i: go to DONE if pop_cnt==num, else back to PUSH.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Combinational outputs: all are decodes of registered state/counters plus inputs. Zero added latency: a granted pop writes the GLB in the same cycle.
- Outside PUSH: ready_o/push_o are 0. Outside DRAIN: write_req_o/pop_o are 0.
- write_ptr is not cleared between tasks; consecutive tasks append. It is cleared only by rst_n or opsum_fifo_reset_i.
- opsum_fifo_reset_i has priority over everything. Next cycle: IDLE, counters and write_ptr 0, no push/pop/req/done.
- need_push_i outside IDLE is ignored.
- Simultaneous full_i and last push: go to DRAIN (same target).
- Permit without request: no effect.
- empty_i is trusted one cycle stale. After the last pop, DRAIN holds one cycle with req=0 before transitioning.

Optional Feature:
OPSUM_RELU_EN:
- Defined: a signed-negative FIFO head (MSB=1) is written to the GLB as 0. ReLU is applied on the write path only; FIFO contents are unchanged.
- Undefined: data is written unmodified.

Test Plan:
1. Reset, then num=4, base=0x100, PE valid every cycle, FIFO depth 8 → 4 pushes; DRAIN writes addr 0x100/0x102/0x104/0x106 with wstrb 0011/1100/0011/1100; done pulses once; IDLE.
2. num=10, FIFO depth 4, permit always 1 → cycles PUSH→DRAIN→PUSH ×3; exactly 10 pushes and 10 pops; final write addr base+18; single done.
3. DRAIN with permit toggling 1,0,0,1 → req held high; pops only on granted cycles; addr advances only on pops.
4. num=0 trigger → DONE next cycle, done pulse; no push, pop or req.
5. Assert opsum_fifo_reset_i mid-DRAIN after 3 pops → next cycle IDLE, req=0; next task starts writing at base+0.
6. With OPSUM_RELU_EN, push 0x8001 and 0x0005 → GLB data 0x00000000 and 0x00050005; without the macro → 0x80018001 and 0x00050005.
